// File: rtl/learn_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// learn_pkg -- shared state encoding, default widths and derived-width helpers
// for the frequency-sweep learning controller (rev 1.0).
package learn_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STEP   = 3'd1,
      SETTLE = 3'd2,
      REQ    = 3'd3,
      CAP    = 3'd4,
      WRITE  = 3'd5
   } state_t;

   localparam int DW_DEF          = 24;
   localparam int IW_DEF          = 13;
   localparam int AW_DEF          = 12;
   localparam int POINTS_DEF      = 2751;
   localparam int SETTLE_CYC_DEF  = 149_997;
   localparam int AVG_LOG2_DEF    = 2;
   localparam int TIMEOUT_CYC_DEF = 1_000_000;

   localparam int ACC_W = DW_DEF + AVG_LOG2_DEF;
   localparam int MAG_W = 2 * DW_DEF + 1;

   function automatic int acc_width(input int dw, input int avg_log2);
      return dw + avg_log2;
   endfunction

   function automatic int mag_width(input int dw);
      return 2 * dw + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/learn_mag2_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// learn_mag2_pipe -- two-stage signed square-sum (re^2 + im^2) with valid and
// address carried alongside; no overflow at any input value (rev 1.0).
module learn_mag2_pipe
   import learn_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic                        clk_50m,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [AW-1:0]               in_addr,
   input  logic signed [DW-1:0]        in_real,
   input  logic signed [DW-1:0]        in_imag,
   output logic                        out_valid,
   output logic [AW-1:0]               out_addr,
   output logic [mag_width(DW)-1:0]    out_mag2
);

   localparam int PW = 2 * DW;

   logic signed [PW-1:0] re_x;
   logic signed [PW-1:0] im_x;
   logic [PW-1:0]        sq_re;
   logic [PW-1:0]        sq_im;
   logic                 v1;
   logic [AW-1:0]        a1;

   // Widen before multiplying so the full product is kept.
   assign re_x = PW'(in_real);
   assign im_x = PW'(in_imag);

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         sq_re     <= '0;
         sq_im     <= '0;
         v1        <= 1'b0;
         a1        <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_mag2  <= '0;
      end else begin
         sq_re     <= re_x * re_x;
         sq_im     <= im_x * im_x;
         v1        <= in_valid;
         a1        <= in_addr;
         out_valid <= v1;
         out_addr  <= a1;
         out_mag2  <= {1'b0, sq_re} + {1'b0, sq_im};
      end
   end

endmodule

`default_nettype wire

// File: rtl/learn_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// learn_sweep_ctrl -- sweep controller: step DDS, settle, average one FFT bin over
// 2^AVG_LOG2 frames, write learn RAMs. Watchdog built only with LEARN_TIMEOUT_EN (rev 1.0).
module learn_sweep_ctrl
   import learn_pkg::*;
#(
   parameter int DW          = DW_DEF,
   parameter int IW          = IW_DEF,
   parameter int AW          = AW_DEF,
   parameter int POINTS      = POINTS_DEF,
   parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
   parameter int AVG_LOG2    = AVG_LOG2_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                     clk_50m,
   input  logic                     rst_n,
   input  logic                     key,
   input  logic                     abort,
   input  logic signed [DW-1:0]     fft_real,
   input  logic signed [DW-1:0]     fft_imag,
   input  logic                     source_valid,
   input  logic [IW-1:0]            freq,
   output logic                     next_freq,
   output logic                     fft_valid,
   output logic                     learn_en,
   output logic                     wr_en,
   output logic [AW-1:0]            wr_addr,
   output logic signed [DW-1:0]     wr_real,
   output logic signed [DW-1:0]     wr_imag,
   output logic                     mag_wren,
   output logic [AW-1:0]            mag_addr,
   output logic [mag_width(DW)-1:0] mag2,
   output logic                     bin_miss,
   output logic                     timeout_err,
   output logic                     learn_done
);

   localparam int ACC_BITS = acc_width(DW, AVG_LOG2);
   localparam int FC_W     = AVG_LOG2 + 1;
   localparam int BC_W     = IW + 1;
   localparam int SC_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   localparam logic [FC_W-1:0] LAST_FRAME  = FC_W'((1 << AVG_LOG2) - 1);
   localparam logic [AW-1:0]   LAST_ADDR   = AW'(POINTS - 1);
   localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

   state_t                    state;
   logic                      key_s1;
   logic                      key_s2;
   logic                      key_d;
   logic                      key_rise;
   logic [SC_W-1:0]           settle_cnt;
   logic [BC_W-1:0]           bin_cnt;
   logic [BC_W-1:0]           cur_bin;
   logic [FC_W-1:0]           frame_cnt;
   logic signed [ACC_BITS-1:0] acc_re;
   logic signed [ACC_BITS-1:0] acc_im;
   logic                      hit_seen;
   logic                      bin_hit;
   logic                      wd_fire;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         key_s1 <= 1'b0;
         key_s2 <= 1'b0;
         key_d  <= 1'b0;
      end else begin
         key_s1 <= key;
         key_s2 <= key_s1;
         key_d  <= key_s2;
      end
   end

   assign key_rise = key_s2 & ~key_d;

   // Bin 0 arrives in the REQ cycle that first sees source_valid.
   assign cur_bin = (state == REQ) ? '0 : bin_cnt;
   assign bin_hit = source_valid && ((state == REQ) || (state == CAP)) &&
                    (cur_bin == BC_W'(freq));

   assign learn_en   = (state != IDLE);
   assign learn_done = (state == IDLE);
   assign next_freq  = (state == STEP)  && !abort;
   assign wr_en      = (state == WRITE) && !abort;
   assign fft_valid  = (state == REQ)   && !source_valid && !abort;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         settle_cnt <= '0;
         bin_cnt    <= '0;
         frame_cnt  <= '0;
         acc_re     <= '0;
         acc_im     <= '0;
         hit_seen   <= 1'b0;
         wr_addr    <= '0;
         wr_real    <= '0;
         wr_imag    <= '0;
         bin_miss   <= 1'b0;
      end else if (abort) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (key_rise) begin
                  state    <= STEP;
                  wr_addr  <= '0;
                  bin_miss <= 1'b0;
               end
            end
            STEP: begin
               acc_re     <= '0;
               acc_im     <= '0;
               frame_cnt  <= '0;
               settle_cnt <= SETTLE_LOAD;
               state      <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == '0) state <= REQ;
               else                  settle_cnt <= settle_cnt - 1'b1;
            end
            REQ: begin
               if (wd_fire) begin
                  wr_real <= '0;
                  wr_imag <= '0;
                  state   <= WRITE;
               end else if (source_valid) begin
                  bin_cnt  <= BC_W'(1);
                  hit_seen <= bin_hit;
                  if (bin_hit) begin
                     acc_re <= acc_re + ACC_BITS'(fft_real);
                     acc_im <= acc_im + ACC_BITS'(fft_imag);
                  end
                  state <= CAP;
               end
            end
            CAP: begin
               if (wd_fire) begin
                  wr_real <= '0;
                  wr_imag <= '0;
                  state   <= WRITE;
               end else if (source_valid) begin
                  bin_cnt <= bin_cnt + 1'b1;
                  if (bin_hit) begin
                     hit_seen <= 1'b1;
                     acc_re   <= acc_re + ACC_BITS'(fft_real);
                     acc_im   <= acc_im + ACC_BITS'(fft_imag);
                  end
               end else begin
                  if (!hit_seen) bin_miss <= 1'b1;
                  frame_cnt <= frame_cnt + 1'b1;
                  if (frame_cnt == LAST_FRAME) begin
                     wr_real <= DW'(acc_re >>> AVG_LOG2);
                     wr_imag <= DW'(acc_im >>> AVG_LOG2);
                     state   <= WRITE;
                  end else begin
                     state <= REQ;
                  end
               end
            end
            WRITE: begin
               if (wr_addr == LAST_ADDR) begin
                  state <= IDLE;
               end else begin
                  wr_addr <= wr_addr + 1'b1;
                  state   <= STEP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LEARN_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wd_cnt;

   assign wd_fire = ((state == REQ) || (state == CAP)) &&
                    (wd_cnt >= WD_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == STEP)                 wd_cnt <= '0;
         else if (learn_en && wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;

         if (!abort) begin
            if ((state == IDLE) && key_rise) timeout_err <= 1'b0;
            else if (wd_fire)                timeout_err <= 1'b1;
         end
      end
   end
`else
   assign wd_fire     = 1'b0;
   // Tied low; the TIMEOUT_CYC term only keeps the parameter referenced.
   assign timeout_err = 1'b0 && (TIMEOUT_CYC > 0);
`endif

   learn_mag2_pipe #(
      .DW (DW),
      .AW (AW)
   ) u_mag2 (
      .clk_50m   (clk_50m),
      .rst_n     (rst_n),
      .in_valid  (wr_en),
      .in_addr   (wr_addr),
      .in_real   (wr_real),
      .in_imag   (wr_imag),
      .out_valid (mag_wren),
      .out_addr  (mag_addr),
      .out_mag2  (mag2)
   );

endmodule

`default_nettype wire

// File: tb/tb_learn_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// tb_learn_sweep_ctrl -- directed bench: 4-point sweeps, averaging, bin miss,
// abort, async reset, busy key and (with LEARN_TIMEOUT_EN) the watchdog.
module tb_learn_sweep_ctrl;

   logic               clk_50m = 1'b0;
   logic               rst_n = 1'b0;
   logic               key = 1'b0;
   logic               abort = 1'b0;
   logic signed [23:0] fft_real = '0;
   logic signed [23:0] fft_imag = '0;
   logic               source_valid = 1'b0;
   logic [12:0]        freq = '0;
   logic               next_freq;
   logic               fft_valid;
   logic               learn_en;
   logic               wr_en;
   logic [11:0]        wr_addr;
   logic signed [23:0] wr_real;
   logic signed [23:0] wr_imag;
   logic               mag_wren;
   logic [11:0]        mag_addr;
   logic [48:0]        mag2;
   logic               bin_miss;
   logic               timeout_err;
   logic               learn_done;

   int n_checks = 0;
   int n_errors = 0;

   learn_sweep_ctrl #(
      .DW          (24),
      .IW          (13),
      .AW          (12),
      .POINTS      (4),
      .SETTLE_CYC  (10),
      .AVG_LOG2    (2),
      .TIMEOUT_CYC (200)
   ) dut (
      .clk_50m      (clk_50m),
      .rst_n        (rst_n),
      .key          (key),
      .abort        (abort),
      .fft_real     (fft_real),
      .fft_imag     (fft_imag),
      .source_valid (source_valid),
      .freq         (freq),
      .next_freq    (next_freq),
      .fft_valid    (fft_valid),
      .learn_en     (learn_en),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_real      (wr_real),
      .wr_imag      (wr_imag),
      .mag_wren     (mag_wren),
      .mag_addr     (mag_addr),
      .mag2         (mag2),
      .bin_miss     (bin_miss),
      .timeout_err  (timeout_err),
      .learn_done   (learn_done)
   );

   always #10 clk_50m = ~clk_50m;

   task automatic check(input string tag, input bit ok);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $error("FAIL %s", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk_50m);
      #1;
   endtask

   // Key edge reaches STEP three clocks after it is raised.
   task automatic press_key();
      key = 1'b1;
      repeat (3) tick();
      check("start_next_freq", next_freq === 1'b1);
      check("start_wr_addr", wr_addr === 12'd0);
      check("start_bin_miss", bin_miss === 1'b0);
      check("start_timeout_err", timeout_err === 1'b0);
      tick();
      key = 1'b0;
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (fft_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check("fft_valid_wait", fft_valid === 1'b1);
   endtask

   task automatic run_frame(input int re_off, input int im_val);
      wait_req();
      for (int i = 0; i < 16; i++) begin
         source_valid = 1'b1;
         fft_real     = 24'(re_off + i);
         fft_imag     = 24'(im_val);
         tick();
      end
      source_valid = 1'b0;
      fft_real     = '0;
      fft_imag     = '0;
   endtask

   task automatic run_point(input int fr, input int o0, input int o1, input int o2,
                            input int o3, input int im, input int ea, input int ere,
                            input int eim, input longint emag, input bit last);
      freq = 13'(fr);
      run_frame(o0, im);
      run_frame(o1, im);
      run_frame(o2, im);
      run_frame(o3, im);
      tick();
      check("wr_en", wr_en === 1'b1);
      check("wr_addr", wr_addr === 12'(ea));
      check("wr_real", wr_real === 24'(ere));
      check("wr_imag", wr_imag === 24'(eim));
      tick();
      check("wr_en_pulse", wr_en === 1'b0);
      check("mag_wren_early", mag_wren === 1'b0);
      check("learn_done_after_wr", learn_done === last);
      tick();
      check("mag_wren", mag_wren === 1'b1);
      check("mag_addr", mag_addr === 12'(ea));
      check("mag2", mag2 === 49'(emag));
   endtask

   initial begin
      int cnt;

      // Reset state
      #5;
      check("rst_learn_done", learn_done === 1'b1);
      check("rst_learn_en", learn_en === 1'b0);
      check("rst_wr_en", wr_en === 1'b0);
      check("rst_fft_valid", fft_valid === 1'b0);
      check("rst_mag2", mag2 === 49'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      check("idle_learn_done", learn_done === 1'b1);

      // Sweep 1: plain capture, averaging, bin miss, negative values
      press_key();
      check("busy_learn_en", learn_en === 1'b1);
      run_point(3, 100, 100, 100, 100, -1, 0, 103, -1, 10610, 1'b0);
      check("p0_bin_miss", bin_miss === 1'b0);
      run_point(3, 1, 5, -7, 9, -1, 1, 5, -1, 26, 1'b0);
      check("p1_bin_miss", bin_miss === 1'b0);
      run_point(20, 0, 0, 0, 0, 7, 2, 0, 0, 0, 1'b0);
      check("p2_bin_miss", bin_miss === 1'b1);
      run_point(3, -200, -200, -200, -200, 50, 3, -197, 50, 41309, 1'b1);
      check("sweep_end_learn_en", learn_en === 1'b0);
      check("sweep_end_bin_miss_sticky", bin_miss === 1'b1);
      check("sweep_timeout_err", timeout_err === 1'b0);

      // Sweep 2: abort inside CAP of point 2
      repeat (3) tick();
      press_key();
      run_point(3, 100, 100, 100, 100, -1, 0, 103, -1, 10610, 1'b0);
      run_point(3, 1, 5, -7, 9, -1, 1, 5, -1, 26, 1'b0);
      freq = 13'd3;
      wait_req();
      for (int i = 0; i < 5; i++) begin
         source_valid = 1'b1;
         fft_real     = 24'(i);
         tick();
      end
      abort = 1'b1;
      #1;
      check("abort_wr_en", wr_en === 1'b0);
      check("abort_fft_valid", fft_valid === 1'b0);
      check("abort_next_freq", next_freq === 1'b0);
      tick();
      abort        = 1'b0;
      source_valid = 1'b0;
      fft_real     = '0;
      check("abort_learn_done", learn_done === 1'b1);
      check("abort_learn_en", learn_en === 1'b0);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (wr_en || fft_valid || next_freq || mag_wren) cnt++;
         tick();
      end
      check("abort_quiet", cnt === 0);

      // Sweep 3: restart at addr 0, busy key ignored, async reset mid-SETTLE
      press_key();
      run_point(3, 100, 100, 100, 100, -1, 0, 103, -1, 10610, 1'b0);
      key = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (next_freq) cnt++;
         tick();
      end
      key = 1'b0;
      check("busy_key_no_restart", cnt === 0);
      check("busy_key_still_busy", learn_en === 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_learn_done", learn_done === 1'b1);
      check("arst_learn_en", learn_en === 1'b0);
      check("arst_wr_addr", wr_addr === 12'd0);
      check("arst_wr_real", wr_real === 24'sd0);
      check("arst_wr_imag", wr_imag === 24'sd0);
      check("arst_mag_addr", mag_addr === 12'd0);
      check("arst_mag2", mag2 === 49'd0);
      check("arst_fft_valid", fft_valid === 1'b0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("post_rst_idle", learn_done === 1'b1);

`ifdef LEARN_TIMEOUT_EN
      // Watchdog: no frames ever arrive, every point written as zero
      press_key();
      for (int p = 0; p < 4; p++) begin
         cnt = 0;
         while (wr_en !== 1'b1 && cnt < 400) begin
            tick();
            cnt++;
         end
         check("to_wr_en", wr_en === 1'b1);
         check("to_wr_addr", wr_addr === 12'(p));
         check("to_wr_real", wr_real === 24'sd0);
         check("to_timeout_err", timeout_err === 1'b1);
         tick();
      end
      check("to_learn_done", learn_done === 1'b1);
`else
      check("no_wd_timeout_err", timeout_err === 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not reach the end");
      $fatal(1, "global timeout");
   end

endmodule

`default_nettype wire

// File: doc/learn_sweep_ctrl.md
Name: learn_sweep_ctrl

Overview:
Single-clock, parametrised frequency-sweep learning controller. For each sweep point it steps the stimulus frequency, waits a settle time, and requests 2^AVG_LOG2 FFT frames. From each frame it captures the bin selected by `freq` and averages the captured values. It then writes the averaged real/imag words plus the magnitude-squared value into the learn RAMs. It sits between the key/DDS front end and the FFT core, and feeds the response RAM used by later compensation.

Parameters:
DW, 24, FFT real/imag width (signed)
IW, 13, bin-index width
AW, 12, RAM address width
POINTS, 2751, sweep points written (addresses 0..POINTS-1)
SETTLE_CYC, 149_997, clk_50m cycles waited after each frequency step
AVG_LOG2, 2, log2 of frames averaged per point (0 = no averaging)
TIMEOUT_CYC, 1_000_000, watchdog limit per point (used only with the optional feature)

Ports:
clk_50m  in  1  sole clock
rst_n  in  1  asynchronous active-low reset
key  in  1  start request, async level; synchronised with 2 flops, rising edge starts
abort  in  1  synchronous abort, returns the block to IDLE
fft_real  in  DW  signed FFT output, real part
fft_imag  in  DW  signed FFT output, imaginary part
source_valid  in  1  high for the contiguous bins of one frame; bin 0 is on the first high cycle
freq  in  IW  bin index to capture at the current point
next_freq  out  1  one-cycle pulse: DDS advances to the next frequency
fft_valid  out  1  frame request
learn_en  out  1  high whenever state is not IDLE
wr_en  out  1  one-cycle write strobe
wr_addr  out  AW  write address
wr_real  out  DW  averaged real part
wr_imag  out  DW  averaged imaginary part
mag_wren  out  1  magnitude write strobe
mag_addr  out  AW  magnitude write address
mag2  out  2*DW+1  unsigned wr_real²+wr_imag²
bin_miss  out  1  sticky flag: some frame ended without index==freq
timeout_err  out  1  sticky watchdog flag (constant 0 when the feature is absent)
learn_done  out  1  high in IDLE

Behaviour:
- Reset values: every output 0 except learn_done=1. State = IDLE; counters and accumulators cleared. Reset mid-sweep behaves identically.
- IDLE
  - Synchronised key rising edge → STEP.
  - Entering STEP clears bin_miss, timeout_err and wr_addr.
  - Key edges while learn_en=1 are ignored.
- STEP (1 cycle): next_freq=1, accumulators and frame count cleared, settle counter loaded → SETTLE.
- SETTLE: counts SETTLE_CYC cycles → REQ.
- REQ: fft_valid=1 until the first cycle of source_valid=1 → CAP. fft_valid drops in that same cycle.
- CAP
  - Bin counter starts at 0 and increments on each source_valid cycle.
  - When counter==freq, sign-extended fft_real/imag are added into accumulators of DW+AVG_LOG2 bits.
  - On the source_valid falling edge the frame count increments. If no hit occurred in the frame, bin_miss=1 and that frame contributes 0.
  - Frame count < 2^AVG_LOG2 → REQ; otherwise → WRITE.
- WRITE (1 cycle)
  - wr_real/wr_imag = accumulator arithmetic-shifted right by AVG_LOG2, truncated to DW bits.
  - wr_en=1 at the current wr_addr.
  - Next state: wr_addr==POINTS-1 → IDLE (learn_done rises the next cycle); otherwise wr_addr+1 → STEP.
- Magnitude pipeline
  - Two registered stages: squares, then sum.
  - mag_wren pulses exactly 2 cycles after wr_en.
  - mag_addr equals the wr_addr of that write; mag2 is full precision with no overflow.
  - The pipeline completes even if state has already returned to IDLE.
- abort (any state): next cycle is IDLE. fft_valid, next_freq and wr_en are forced 0. A magnitude write already in flight still completes. abort has priority over every transition.
- freq ≥ frame length: every frame misses, point written as 0, bin_miss=1.

Optional Feature:
LEARN_TIMEOUT_EN
- Defined: a per-point watchdog counts clk_50m cycles from STEP. Reaching TIMEOUT_CYC in REQ or CAP sets timeout_err=1. The block then writes 0 to that point and continues with the next point, so the sweep always terminates.
- Undefined: no watchdog logic; timeout_err tied 0; REQ/CAP wait indefinitely.

Decomposition:
- Package learn_pkg holds:
  - the state enum (IDLE, STEP, SETTLE, REQ, CAP, WRITE);
  - the default widths;
  - localparams for accumulator width DW+AVG_LOG2 and magnitude width 2*DW+1.
- One sub-module, learn_mag2_pipe: 2-stage signed square-sum with valid/address pass-through.

Test Plan:
1. POINTS=4, AVG_LOG2=0, SETTLE_CYC=10, 16-bin frames, bin value = 100+index, freq=3 → 4 writes at addr 0..3, wr_real=103. Each mag_wren lands 2 cycles after its wr_en. learn_done rises after the 4th write.
2. AVG_LOG2=2, captured real values 4, 8, −4, 12 → wr_real=5. Imag values −1 ×4 → wr_imag=−1.
3. freq=20 with 16-bin frames → wr_real=wr_imag=0, bin_miss=1. bin_miss clears on the next start.
4. abort asserted in CAP of point 2 → IDLE the next cycle, no further wr_en, learn_done=1. A key edge then restarts at addr 0.
5. rst_n pulsed low mid-SETTLE → all outputs at reset values asynchronously. A key pressed while busy has no effect.
6. With LEARN_TIMEOUT_EN, TIMEOUT_CYC=200 and source_valid held low → timeout_err=1, the point is written as 0, and the sweep completes.
